ama_riscv_bp_gshare: RTL and testbench

Gshare conditional-branch direction predictor feeding the front-end control block. It produces a taken/not-taken prediction for the branch currently in decode, checkpoints the prediction context when the front end commits to speculating, and trains its pattern table when execute resolves the branch. On a misprediction it repairs the global history from the checkpoint. At most one speculative branch is outstanding, matching the front-end speculation model.

---
 rtl/ama_riscv_bp_gshare.sv | 117 +++++++++++
 tb/tb_ama_riscv_bp_gshare.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ama_riscv_bp_gshare.sv
// rtl/ama_riscv_bp_gshare.sv - gshare branch direction predictor with one-deep speculation checkpoint
module ama_riscv_bp_gshare #(
  parameter int IDX_BITS = 7,
  parameter int GHR_BITS = 7,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_dec,
  input  logic             branch_inst_dec,
  input  logic             spec_enter,
  input  logic             spec_resolve,
  input  logic             branch_resolution,
  output logic             bp_pred,
  output logic             bp_pending,
  output logic             bp_mispred,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          pht_q [ENTRIES];
  logic [1:0]          pht_d [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [GHR_BITS-1:0] ck_ghr_q, ck_ghr_d;
  logic [IDX_BITS-1:0] ck_idx_q, ck_idx_d;
  logic                ck_pred_q, ck_pred_d;
  logic                pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0]    cnt_mp_q, cnt_mp_d;

  logic [IDX_BITS-1:0] idx;
  logic                resolve_v;
  logic                mispred;
  logic                enter_ok;
  logic [1:0]          ck_cnt;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{pc_dec[31:IDX_BITS+2], pc_dec[1:0]};

  assign idx       = pc_dec[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign bp_pred   = branch_inst_dec & pht_q[idx][1];
  assign resolve_v = spec_resolve & pending_q;
  assign mispred   = resolve_v & (branch_resolution != ck_pred_q);
  // A new branch may take over the checkpoint only when the old one retires correctly
  assign enter_ok  = spec_enter & (~pending_q | (resolve_v & ~mispred));
  assign ck_cnt    = pht_q[ck_idx_q];

  assign bp_pending   = pending_q;
  assign bp_mispred   = mispred;
  assign cnt_branches = cnt_br_q;
  assign cnt_mispred  = cnt_mp_q;

  always_comb begin
    pht_d     = pht_q;
    ghr_d     = ghr_q;
    ck_idx_d  = ck_idx_q;
    ck_ghr_d  = ck_ghr_q;
    ck_pred_d = ck_pred_q;
    pending_d = pending_q;
    cnt_br_d  = cnt_br_q;
    cnt_mp_d  = cnt_mp_q;

    if (resolve_v) begin
      if (branch_resolution) begin
        pht_d[ck_idx_q] = (ck_cnt == 2'b11) ? 2'b11 : ck_cnt + 2'd1;
      end else begin
        pht_d[ck_idx_q] = (ck_cnt == 2'b00) ? 2'b00 : ck_cnt - 2'd1;
      end
      pending_d = 1'b0;
      cnt_br_d  = (&cnt_br_q) ? cnt_br_q : cnt_br_q + 1'b1;
      if (mispred) begin
        cnt_mp_d = (&cnt_mp_q) ? cnt_mp_q : cnt_mp_q + 1'b1;
      end
    end

    // Repair restarts history from the checkpoint with the real outcome
    if (mispred) begin
      ghr_d = GHR_BITS'({ck_ghr_q, branch_resolution});
    end else if (enter_ok) begin
      ghr_d = GHR_BITS'({ghr_q, bp_pred});
    end

    if (enter_ok) begin
      ck_idx_d  = idx;
      ck_ghr_d  = ghr_q;
      ck_pred_d = bp_pred;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
      ghr_q     <= '0;
      ck_idx_q  <= '0;
      ck_ghr_q  <= '0;
      ck_pred_q <= 1'b0;
      pending_q <= 1'b0;
      cnt_br_q  <= '0;
      cnt_mp_q  <= '0;
    end else begin
      pht_q     <= pht_d;
      ghr_q     <= ghr_d;
      ck_idx_q  <= ck_idx_d;
      ck_ghr_q  <= ck_ghr_d;
      ck_pred_q <= ck_pred_d;
      pending_q <= pending_d;
      cnt_br_q  <= cnt_br_d;
      cnt_mp_q  <= cnt_mp_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_bp_gshare.sv
// tb/tb_ama_riscv_bp_gshare.sv - scoreboard bench for the gshare predictor
module tb_ama_riscv_bp_gshare;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_dec;
  logic        branch_inst_dec, spec_enter, spec_resolve, branch_resolution;
  logic        bp_pred, bp_pending, bp_mispred;
  logic [31:0] cnt_branches, cnt_mispred;

  ama_riscv_bp_gshare dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_dec            (pc_dec),
    .branch_inst_dec   (branch_inst_dec),
    .spec_enter        (spec_enter),
    .spec_resolve      (spec_resolve),
    .branch_resolution (branch_resolution),
    .bp_pred           (bp_pred),
    .bp_pending        (bp_pending),
    .bp_mispred        (bp_mispred),
    .cnt_branches      (cnt_branches),
    .cnt_mispred       (cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pred;
    logic        pend;
    logic        misp;
    logic [31:0] cb;
    logic [31:0] cm;
    logic [6:0]  ghr;
    logic [6:0]  ck;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per presented cycle, mid-cycle away from the edge
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.tag, ".bp_pred"},    32'(bp_pred),         32'(e.pred));
        cmp({e.tag, ".bp_pending"}, 32'(bp_pending),      32'(e.pend));
        cmp({e.tag, ".bp_mispred"}, 32'(bp_mispred),      32'(e.misp));
        cmp({e.tag, ".cnt_br"},     cnt_branches,         e.cb);
        cmp({e.tag, ".cnt_mp"},     cnt_mispred,          e.cm);
        cmp({e.tag, ".ghr"},        32'(dut.ghr_q),       32'(e.ghr));
        cmp({e.tag, ".ck_idx"},     32'(dut.ck_idx_q),    32'(e.ck));
      end
    end
  end

  task automatic step(input string tag, input logic [31:0] pc, input logic br,
                      input logic en, input logic rs, input logic res,
                      input logic ep, input logic epend, input logic emisp,
                      input logic [31:0] ecb, input logic [31:0] ecm,
                      input logic [6:0] eghr, input logic [6:0] eck);
    exp_t e;
    pc_dec            = pc;
    branch_inst_dec   = br;
    spec_enter        = en;
    spec_resolve      = rs;
    branch_resolution = res;
    e.tag = tag; e.pred = ep; e.pend = epend; e.misp = emisp;
    e.cb = ecb; e.cm = ecm; e.ghr = eghr; e.ck = eck;
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pc_dec = '0; branch_inst_dec = 0; spec_enter = 0; spec_resolve = 0; branch_resolution = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    //    tag  pc        br en rs res | pred pend misp cb cm ghr   ck
    step("A", 32'h100, 1, 0, 0, 0,   0, 0, 0, 0, 0, 7'h00, 7'h00);
    step("B", 32'h100, 1, 1, 0, 0,   0, 0, 0, 0, 0, 7'h00, 7'h00);
    step("C", 32'h100, 1, 0, 1, 1,   0, 1, 1, 0, 0, 7'h00, 7'h40);
    step("D", 32'h104, 1, 0, 0, 0,   1, 0, 0, 1, 1, 7'h01, 7'h40);
    step("E", 32'h104, 1, 1, 0, 0,   1, 0, 0, 1, 1, 7'h01, 7'h40);
    step("F", 32'h204, 1, 1, 1, 1,   0, 1, 0, 1, 1, 7'h03, 7'h40);
    step("G", 32'h300, 1, 1, 0, 0,   0, 1, 0, 2, 1, 7'h06, 7'h02);
    step("H", 32'h300, 1, 1, 1, 1,   0, 1, 1, 2, 1, 7'h06, 7'h02);
    step("I", 32'h200, 0, 0, 1, 0,   0, 0, 0, 3, 2, 7'h07, 7'h02);
    step("J", 32'h014, 1, 0, 0, 0,   1, 0, 0, 3, 2, 7'h07, 7'h02);
    step("K", 32'h11C, 1, 1, 0, 0,   1, 0, 0, 3, 2, 7'h07, 7'h02);
    step("L", 32'h11C, 1, 0, 1, 1,   0, 1, 0, 3, 2, 7'h0F, 7'h40);
    step("M", 32'h13C, 1, 1, 0, 0,   1, 0, 0, 4, 2, 7'h0F, 7'h40);
    step("N", 32'h13C, 1, 0, 1, 0,   0, 1, 1, 4, 2, 7'h1F, 7'h40);
    step("O", 32'h178, 1, 0, 0, 0,   1, 0, 0, 5, 3, 7'h1E, 7'h40);
    step("P", 32'h178, 1, 1, 0, 0,   1, 0, 0, 5, 3, 7'h1E, 7'h40);
    rst_n = 1'b0;
    step("Q", 32'h178, 1, 0, 1, 1,   0, 0, 0, 0, 0, 7'h00, 7'h00);
    rst_n = 1'b1;
    step("R", 32'h100, 1, 0, 0, 0,   0, 0, 0, 0, 0, 7'h00, 7'h00);
    chk = 1'b0;
    spec_enter = 0; spec_resolve = 0;
    repeat (2) @(posedge clk);
    cmp("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
